// File: rtl/encoder_32to5_rr_if.sv
// Request/issue bundle for encoder_32to5_rr: request lines in, encoded index stream out.
interface encoder_32to5_rr_if;
  logic        en;
  logic [0:31] req;
  logic        out_ready;
  logic        out_valid;
  logic [0:4]  out_idx;
  logic [0:31] pending;
  logic        busy;

  modport master (output en, req, out_ready, input out_valid, out_idx, pending, busy);
  modport slave  (input en, req, out_ready, output out_valid, out_idx, pending, busy);
endinterface

// File: rtl/encoder_32to5_rr.sv
// Sticky 32-line request set serialised into a 5-bit index stream over valid/ready,
// picked round-robin from a rotating pointer (RR=1) or lowest index first (RR=0).
module encoder_32to5_rr #(
  parameter bit RR = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  encoder_32to5_rr_if.slave  bus
);

  logic [0:31] pend_q;
  logic        valid_q;
  logic [0:4]  idx_q;
  logic [4:0]  ptr;

  logic [4:0]  sel;
  logic [4:0]  cand;
  logic        found;
  logic        free;
  logic        issue;
  logic [0:31] clr_mask;

  // Scan upward from the start point with natural 5-bit wrap; RR=0 always starts at 0.
  always_comb begin
    sel   = 5'd0;
    cand  = 5'd0;
    found = 1'b0;
    for (int off = 0; off < 32; off++) begin
      cand = (RR ? ptr : 5'd0) + 5'(off);
      if (!found && pend_q[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign free  = ~valid_q | bus.out_ready;
  assign issue = bus.en & free & found;

  always_comb begin
    clr_mask = '0;
    if (issue) clr_mask[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr     <= 5'd0;
    end else begin
      // New requests win over the issue-clear so a re-request re-arms the line.
      pend_q <= (pend_q & ~clr_mask) | bus.req;
      if (issue) begin
        valid_q <= 1'b1;
        idx_q   <= sel;
        if (RR) ptr <= sel + 5'd1;
      end else if (free) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.pending   = pend_q;
  assign bus.out_valid = valid_q;
  assign bus.out_idx   = idx_q;
  assign bus.busy      = (|pend_q) | valid_q;

endmodule

// File: tb/tb_encoder_32to5_rr.sv
// Bench for encoder_32to5_rr: round-robin and fixed-priority instances share stimulus.
module tb_encoder_32to5_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic        drv_en;
  logic [0:31] drv_req;
  logic        drv_ready;

  int n_checks = 0;
  int n_fail   = 0;

  encoder_32to5_rr_if bus_rr ();
  encoder_32to5_rr_if bus_fp ();

  assign bus_rr.en        = drv_en;
  assign bus_rr.req       = drv_req;
  assign bus_rr.out_ready = drv_ready;
  assign bus_fp.en        = drv_en;
  assign bus_fp.req       = drv_req;
  assign bus_fp.out_ready = drv_ready;

  encoder_32to5_rr #(.RR(1'b1)) dut_rr (.clk(clk), .reset(rst), .bus(bus_rr));
  encoder_32to5_rr #(.RR(1'b0)) dut_fp (.clk(clk), .reset(rst), .bus(bus_fp));

  always #5 clk = ~clk;

  // Reference model: [0] round-robin, [1] fixed priority.
  bit [0:31] m_pend  [2];
  bit        m_valid [2];
  int        m_idx   [2];
  int        m_ptr   [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit fr;
      int sel;
      int start;
      if (rst) begin
        m_pend[i] = '0; m_valid[i] = 0; m_idx[i] = 0; m_ptr[i] = 0;
      end else begin
        fr    = !m_valid[i] || drv_ready;
        sel   = -1;
        start = (i == 0) ? m_ptr[i] : 0;
        if (drv_en && fr) begin
          for (int off = 0; off < 32; off++) begin
            if (sel < 0 && m_pend[i][(start + off) % 32]) sel = (start + off) % 32;
          end
        end
        if (sel >= 0) begin
          m_pend[i][sel] = 1'b0;
          m_valid[i]     = 1'b1;
          m_idx[i]       = sel;
          m_ptr[i]       = (sel + 1) % 32;
        end else if (fr) begin
          m_valid[i] = 1'b0;
        end
        m_pend[i] = m_pend[i] | drv_req;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; drv_req = '1; drv_en = 1'b1; drv_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; drv_req = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus_rr.pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending got %h want 0", bus_rr.pending); end
    n_checks++; if (bus_rr.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus_rr.out_valid); end
    n_checks++; if (bus_rr.out_idx !== 5'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", bus_rr.out_idx); end
    n_checks++; if (bus_rr.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus_rr.busy); end
    n_checks++; if (bus_fp.busy !== 1'b0 || bus_fp.pending !== 32'h0) begin n_fail++; $display("FAIL reset_fp busy %b pending %h want 0/0", bus_fp.busy, bus_fp.pending); end
  endtask

  task automatic test_single();
    do_reset();
    drv_req[5] = 1'b1;
    tick();
    drv_req = '0;
    n_checks++; if (bus_rr.pending[5] !== 1'b1 || bus_rr.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_capture pending5 %b valid %b want 1/0", bus_rr.pending[5], bus_rr.out_valid); end
    tick();
    n_checks++; if (bus_rr.out_valid !== 1'b1 || bus_rr.out_idx !== 5'b00101) begin n_fail++; $display("FAIL single_issue valid %b idx %0d want 1/5", bus_rr.out_valid, bus_rr.out_idx); end
    tick();
    n_checks++; if (bus_rr.out_valid !== 1'b0 || bus_rr.pending !== 32'h0 || bus_rr.busy !== 1'b0) begin n_fail++; $display("FAIL single_drain valid %b pending %h busy %b want 0/0/0", bus_rr.out_valid, bus_rr.pending, bus_rr.busy); end
  endtask

  task automatic test_burst();
    int exp_seq [3] = '{0, 3, 31};
    do_reset();
    drv_req[0] = 1'b1; drv_req[3] = 1'b1; drv_req[31] = 1'b1;
    tick();
    drv_req = '0;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_checks++; if (bus_rr.out_valid !== 1'b1 || bus_rr.out_idx !== 5'(exp_seq[j])) begin n_fail++; $display("FAIL burst_%0d valid %b idx %0d want 1/%0d", j, bus_rr.out_valid, bus_rr.out_idx, exp_seq[j]); end
    end
    // Pointer must have wrapped to 0, so 0 beats 5.
    drv_req[0] = 1'b1; drv_req[5] = 1'b1;
    tick();
    drv_req = '0;
    tick();
    n_checks++; if (bus_rr.out_idx !== 5'd0 || bus_rr.out_valid !== 1'b1) begin n_fail++; $display("FAIL burst_wrap idx %0d valid %b want 0/1", bus_rr.out_idx, bus_rr.out_valid); end
    tick();
    n_checks++; if (bus_rr.out_idx !== 5'd5 || bus_rr.out_valid !== 1'b1) begin n_fail++; $display("FAIL burst_after_wrap idx %0d valid %b want 5/1", bus_rr.out_idx, bus_rr.out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drv_ready = 1'b0;
    drv_req[3] = 1'b1; drv_req[7] = 1'b1;
    tick();
    drv_req = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (bus_rr.out_valid !== 1'b1 || bus_rr.out_idx !== 5'd3) begin n_fail++; $display("FAIL stall_%0d valid %b idx %0d want 1/3", c, bus_rr.out_valid, bus_rr.out_idx); end
    end
    drv_ready = 1'b1;
    tick();
    n_checks++; if (bus_rr.out_valid !== 1'b1 || bus_rr.out_idx !== 5'd7) begin n_fail++; $display("FAIL stall_release valid %b idx %0d want 1/7", bus_rr.out_valid, bus_rr.out_idx); end
    tick();
    n_checks++; if (bus_rr.out_valid !== 1'b0 || bus_rr.busy !== 1'b0) begin n_fail++; $display("FAIL stall_drain valid %b busy %b want 0/0", bus_rr.out_valid, bus_rr.busy); end
  endtask

  task automatic test_fairness();
    int exp_rr;
    do_reset();
    drv_req[1] = 1'b1; drv_req[2] = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      tick();
      exp_rr = (c % 2 == 0) ? 1 : 2;
      n_checks++; if (bus_rr.out_valid !== 1'b1 || bus_rr.out_idx !== 5'(exp_rr)) begin n_fail++; $display("FAIL fair_rr_%0d valid %b idx %0d want 1/%0d", c, bus_rr.out_valid, bus_rr.out_idx, exp_rr); end
      n_checks++; if (bus_fp.out_valid !== 1'b1 || bus_fp.out_idx !== 5'd1) begin n_fail++; $display("FAIL fair_fp_%0d valid %b idx %0d want 1/1", c, bus_fp.out_valid, bus_fp.out_idx); end
      n_checks++; if (bus_rr.pending[1] !== 1'b1 || bus_fp.pending[1] !== 1'b1) begin n_fail++; $display("FAIL fair_rearm_%0d rr %b fp %b want 1/1", c, bus_rr.pending[1], bus_fp.pending[1]); end
    end
    drv_req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_enable();
    do_reset();
    drv_en = 1'b0;
    drv_req[10] = 1'b1;
    tick();
    drv_req = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (bus_rr.out_valid !== 1'b0 || bus_rr.pending[10] !== 1'b1) begin n_fail++; $display("FAIL en_hold_%0d valid %b pending10 %b want 0/1", c, bus_rr.out_valid, bus_rr.pending[10]); end
    end
    drv_en = 1'b1;
    tick();
    n_checks++; if (bus_rr.out_valid !== 1'b1 || bus_rr.out_idx !== 5'd10 || bus_rr.pending[10] !== 1'b0) begin n_fail++; $display("FAIL en_issue valid %b idx %0d pending10 %b want 1/10/0", bus_rr.out_valid, bus_rr.out_idx, bus_rr.pending[10]); end

    do_reset();
    drv_ready = 1'b0;
    drv_req[10] = 1'b1;
    tick();
    drv_req = '0;
    tick();
    drv_req[11] = 1'b1;
    tick();
    drv_req = '0;
    n_checks++; if (bus_rr.out_valid !== 1'b1 || bus_rr.out_idx !== 5'd10 || bus_rr.pending[11] !== 1'b1) begin n_fail++; $display("FAIL rst_pre valid %b idx %0d pending11 %b want 1/10/1", bus_rr.out_valid, bus_rr.out_idx, bus_rr.pending[11]); end
    rst = 1'b1; drv_req = '1; drv_ready = 1'b1;
    tick();
    n_checks++; if (bus_rr.out_valid !== 1'b0 || bus_rr.pending !== 32'h0 || bus_rr.out_idx !== 5'd0 || bus_rr.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid valid %b pending %h idx %0d busy %b want 0/0/0/0", bus_rr.out_valid, bus_rr.pending, bus_rr.out_idx, bus_rr.busy); end
    rst = 1'b0; drv_req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drv_req   = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
      drv_en    = ($urandom_range(0, 7) != 0);
      drv_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
      n_checks++; if (bus_rr.pending !== m_pend[0] || bus_fp.pending !== m_pend[1]) begin n_fail++; $display("FAIL rand_pending_%0d rr %h fp %h want %h %h", c, bus_rr.pending, bus_fp.pending, m_pend[0], m_pend[1]); end
      n_checks++; if (bus_rr.out_valid !== m_valid[0] || bus_fp.out_valid !== m_valid[1]) begin n_fail++; $display("FAIL rand_valid_%0d rr %b fp %b want %b %b", c, bus_rr.out_valid, bus_fp.out_valid, m_valid[0], m_valid[1]); end
      n_checks++; if (bus_rr.out_idx !== 5'(m_idx[0]) || bus_fp.out_idx !== 5'(m_idx[1])) begin n_fail++; $display("FAIL rand_idx_%0d rr %0d fp %0d want %0d %0d", c, bus_rr.out_idx, bus_fp.out_idx, m_idx[0], m_idx[1]); end
      n_checks++; if (bus_rr.busy !== (m_valid[0] || m_pend[0] != 0) || bus_fp.busy !== (m_valid[1] || m_pend[1] != 0)) begin n_fail++; $display("FAIL rand_busy_%0d rr %b fp %b", c, bus_rr.busy, bus_fp.busy); end
    end
    rst = 1'b0; drv_req = '0;
  endtask

  initial begin
    rst = 1'b1; drv_en = 1'b1; drv_req = '0; drv_ready = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_fairness();
    test_enable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
